// File: rtl/gyro_scale_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gyro_scale_pkg
// Description : Shared types and constants for the gyro rate scaler:
//               FSM state encoding, default full-scale coefficients and
//               helpers for accumulator width and rounding shift.
// Revision    : 1.0 - initial release
// ============================================================================
package gyro_scale_pkg;

  // Control FSM of the scaler
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } state_t;

  // round(2^24 / sensitivity) for the four full-scale ranges
  localparam int unsigned COEF0_DEF = 128070;   // +-250  dps, 131  LSB/dps
  localparam int unsigned COEF1_DEF = 256141;   // +-500  dps, 65.5 LSB/dps
  localparam int unsigned COEF2_DEF = 511500;   // +-1000 dps, 32.8 LSB/dps
  localparam int unsigned COEF3_DEF = 1023001;  // +-2000 dps, 16.4 LSB/dps

  // Accumulator width: (IN_W+1)-bit difference times COEF_W-bit magnitude, plus sign
  function automatic int acc_width(input int in_w, input int coef_w);
    return in_w + coef_w + 2;
  endfunction

  // Right shift that drops the coefficient scale down to the output fraction
  function automatic int rnd_shift(input int coef_shift, input int frac_w);
    return coef_shift - frac_w;
  endfunction

  // Values for the default parameter set
  localparam int ACC_W = acc_width(16, 24);
  localparam int S     = rnd_shift(24, 16);

endpackage
`default_nettype wire

// File: rtl/serial_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module      : serial_shift_add_mult
// Description : Signed x unsigned iterative multiplier, one multiplier bit
//               per cycle, LSB first. start_i clears the accumulator; done_o
//               flags the cycle in which the final partial product is added.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_shift_add_mult #(
  parameter int A_W   = 17,
  parameter int B_W   = 24,
  parameter int ACC_W = 42
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic        [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    done_o
);

  localparam int BIT_W = (B_W > 1) ? $clog2(B_W) : 1;

  logic                    run_q;
  logic [BIT_W-1:0]        bit_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] a_ext_w;
  logic signed [ACC_W-1:0] term_w;

  // Operands are held stable by the caller for the whole multiplication
  assign a_ext_w = ACC_W'(a_i);
  assign term_w  = b_i[bit_q] ? (a_ext_w <<< bit_q) : '0;
  assign done_o  = run_q && (bit_q == BIT_W'(B_W - 1));
  assign acc_o   = acc_q;

  // One shift-add step per cycle until the top multiplier bit is consumed
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      bit_q <= '0;
      acc_q <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      bit_q <= '0;
      acc_q <= '0;
    end else if (run_q) begin
      acc_q <= acc_q + term_w;
      if (done_o) begin
        run_q <= 1'b0;
      end else begin
        bit_q <= bit_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/gyro_rate_scaler.sv
`default_nettype none
// ============================================================================
// Module      : gyro_rate_scaler
// Description : Multi-channel gyro pre-processor. Subtracts bias, multiplies
//               by the full-scale coefficient with a serial multiplier, rounds
//               to Q(OUT_W-FRAC_W).FRAC_W dps and publishes all channels at
//               once. Counts sample sets offered while busy.
//               Build option GYRO_RATE_SAT_EN: clamp instead of wrap when the
//               rounded result exceeds OUT_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module gyro_rate_scaler
  import gyro_scale_pkg::*;
#(
  parameter int                CH_NUM     = 3,
  parameter int                IN_W       = 16,
  parameter int                FRAC_W     = 16,
  parameter int                OUT_W      = 32,
  parameter int                COEF_W     = 24,
  parameter int                COEF_SHIFT = 24,
  parameter logic [COEF_W-1:0] COEF0      = COEF_W'(COEF0_DEF),
  parameter logic [COEF_W-1:0] COEF1      = COEF_W'(COEF1_DEF),
  parameter logic [COEF_W-1:0] COEF2      = COEF_W'(COEF2_DEF),
  parameter logic [COEF_W-1:0] COEF3      = COEF_W'(COEF3_DEF)
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      en_in,
  input  logic [CH_NUM*IN_W-1:0]    x_in,
  input  logic [CH_NUM*IN_W-1:0]    bias_in,
  input  logic [1:0]                fs_sel_in,
  input  logic                      in_vld,
  output logic                      in_rdy,
  output logic [CH_NUM*OUT_W-1:0]   rate_out,
  output logic                      out_vld,
  output logic                      busy_out,
  output logic [7:0]                drop_cnt_out
);

  localparam int DW        = IN_W + 1;
  localparam int ACC_WIDTH = acc_width(IN_W, COEF_W);
  localparam int RND_SHIFT = rnd_shift(COEF_SHIFT, FRAC_W);
  localparam int CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic [COEF_W-1:0]        coef_q;
  logic [COEF_W-1:0]        coef_sel_w;
  logic signed [DW-1:0]     d_q    [CH_NUM];
  logic signed [OUT_W-1:0]  work_q [CH_NUM];
  logic [CH_NUM*OUT_W-1:0]  rate_q;
  logic                     out_vld_q;
  logic [7:0]               drop_q;

  logic                     accept_w;
  logic                     mul_start_w;
  logic                     mul_done_w;
  logic                     rnd_wr_w;
  logic                     publish_w;
  logic signed [DW-1:0]     a_sel_w;
  logic signed [ACC_WIDTH-1:0] acc_w;
  logic signed [ACC_WIDTH-1:0] rnd_w;
  logic signed [OUT_W-1:0]  narrow_w;

  assign in_rdy       = en_in && (state_q == IDLE);
  assign accept_w     = in_vld && in_rdy;
  assign busy_out     = (state_q != IDLE);
  assign rate_out     = rate_q;
  assign out_vld      = out_vld_q;
  assign drop_cnt_out = drop_q;

  // Full-scale coefficient chosen by the range select
  always_comb begin
    coef_sel_w = COEF0;
    case (fs_sel_in)
      2'd1:    coef_sel_w = COEF1;
      2'd2:    coef_sel_w = COEF2;
      2'd3:    coef_sel_w = COEF3;
      default: coef_sel_w = COEF0;
    endcase
  end

  // State register and channel index
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Next-state logic: multiply each channel, round it, then publish all
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    mul_start_w = 1'b0;
    rnd_wr_w    = 1'b0;
    publish_w   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          state_d     = MUL;
          ch_d        = '0;
          mul_start_w = 1'b1;
        end
      end
      MUL: begin
        if (mul_done_w) begin
          state_d = RND;
        end
      end
      RND: begin
        rnd_wr_w = 1'b1;
        if (ch_q == CH_W'(CH_NUM - 1)) begin
          state_d = DONE;
        end else begin
          ch_d        = ch_q + 1'b1;
          state_d     = MUL;
          mul_start_w = 1'b1;
        end
      end
      DONE: begin
        publish_w = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture bias-corrected samples and the coefficient at accept; the extra
  // bit keeps x - bias exact over the full input range
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      coef_q <= '0;
      for (int k = 0; k < CH_NUM; k++) begin
        d_q[k] <= '0;
      end
    end else if (accept_w) begin
      coef_q <= coef_sel_w;
      for (int k = 0; k < CH_NUM; k++) begin
        d_q[k] <= DW'($signed(x_in[k*IN_W +: IN_W])) - DW'($signed(bias_in[k*IN_W +: IN_W]));
      end
    end
  end

  // Multiplicand of the channel currently being processed
  always_comb begin
    a_sel_w = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (ch_q == CH_W'(k)) begin
        a_sel_w = d_q[k];
      end
    end
  end

  serial_shift_add_mult #(
    .A_W   (DW),
    .B_W   (COEF_W),
    .ACC_W (ACC_WIDTH)
  ) u_mult (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .start_i (mul_start_w),
    .a_i     (a_sel_w),
    .b_i     (coef_q),
    .acc_o   (acc_w),
    .done_o  (mul_done_w)
  );

  generate
    if (RND_SHIFT > 0) begin : g_rnd
      localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) <<< (RND_SHIFT - 1);
      assign rnd_w = (acc_w + HALF) >>> RND_SHIFT;
    end else begin : g_no_rnd
      assign rnd_w = acc_w;
    end
  endgenerate

`ifdef GYRO_RATE_SAT_EN
  logic [ACC_WIDTH-OUT_W:0] hi_w;
  logic                     ovf_w;
  // Bits above the output sign must all match it, otherwise the result is out of range
  assign hi_w  = rnd_w[ACC_WIDTH-1:OUT_W-1];
  assign ovf_w = ~((&hi_w) | ~(|hi_w));

  // Clamp to the most negative / most positive OUT_W value on overflow
  always_comb begin
    narrow_w = OUT_W'(rnd_w);
    if (ovf_w) begin
      narrow_w = rnd_w[ACC_WIDTH-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  // Two's-complement wrap to the output width
  always_comb begin
    narrow_w = OUT_W'(rnd_w);
  end
`endif

  // Working registers: one rounded result per channel, hidden until DONE
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH_NUM; k++) begin
        work_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (rnd_wr_w && (ch_q == CH_W'(k))) begin
          work_q[k] <= narrow_w;
        end
      end
    end
  end

  // Publish all channels together with a single-cycle valid
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rate_q    <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_vld_q <= publish_w;
      if (publish_w) begin
        for (int k = 0; k < CH_NUM; k++) begin
          rate_q[k*OUT_W +: OUT_W] <= work_q[k];
        end
      end
    end
  end

  // Saturating count of sample sets offered while the block is busy
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (in_vld && en_in && !in_rdy && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

endmodule
`default_nettype wire
